screen_flusher: RTL and testbench

- Raster-scan driver that is the consumer side of the character/sprite pixel interface.
- It walks every screen coordinate and presents it on flush_x/flush_y.
- It samples the returned colour/enable pair from the combined pixel sources and issues registered single-pixel writes to the VGA adapter write port.
- It sits between the character pixel sources and the VGA adapter; one start pulse redraws one full frame.

---
 rtl/screen_pkg.sv | 16 +
 rtl/raster_counter.sv | 55 +++++
 rtl/screen_flusher.sv | 119 +++++++++++
 tb/tb_screen_flusher.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared widths, default screen size and flusher state encoding.
package screen_pkg;

  localparam int COORD_W        = 8;
  localparam int COLOUR_W       = 6;
  localparam int DEFAULT_WIDTH  = 160;
  localparam int DEFAULT_HEIGHT = 120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } flusher_state_e;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - x/y raster counter with advance, row wrap and last-pixel flag.
module raster_counter
  import screen_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  // Compare against the last index so WIDTH/HEIGHT of 256 never needs a 9th bit.
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               row_end;

  always_comb begin
    row_end = (x_q == X_LAST);
    last    = row_end && (y_q == Y_LAST);
    x_d     = x_q;
    y_d     = y_q;
    if (advance) begin
      if (last) begin
        x_d = '0;
        y_d = '0;
      end else if (row_end) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/screen_flusher.sv
// rtl/screen_flusher.sv - raster sweep of pixel sources into registered VGA writes.
// Optional macro SCREEN_FLUSHER_BG_FILL_EN: write every pixel, bg_colour where no source owns it.
module screen_flusher
  import screen_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                hold,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic [COLOUR_W-1:0] src_colour,
  input  logic                src_enable,
  output logic [COORD_W-1:0]  flush_x,
  output logic [COORD_W-1:0]  flush_y,
  output logic [COORD_W-1:0]  vga_x,
  output logic [COORD_W-1:0]  vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done,
  output logic [7:0]          frame_count
);

  flusher_state_e      state_q, state_d;
  logic                advance;
  logic                last_pixel;
  logic [COORD_W-1:0]  vga_x_q, vga_x_d;
  logic [COORD_W-1:0]  vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;
  logic [7:0]          frame_count_q, frame_count_d;

`ifndef SCREEN_FLUSHER_BG_FILL_EN
  logic unused_bg;
  assign unused_bg = ^bg_colour;
`endif

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clock   (clock),
    .resetn  (resetn),
    .advance (advance),
    .x       (flush_x),
    .y       (flush_y),
    .last    (last_pixel)
  );

  always_comb begin
    state_d       = state_q;
    advance       = 1'b0;
    vga_x_d       = vga_x_q;
    vga_y_d       = vga_y_q;
    vga_colour_d  = vga_colour_q;
    vga_plot_d    = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SWEEP;
      end
      SWEEP: begin
        if (!hold) begin
          advance = 1'b1;
          vga_x_d = flush_x;
          vga_y_d = flush_y;
`ifdef SCREEN_FLUSHER_BG_FILL_EN
          vga_plot_d   = 1'b1;
          vga_colour_d = src_enable ? src_colour : bg_colour;
`else
          vga_plot_d = src_enable;
          if (src_enable) vga_colour_d = src_colour;
`endif
          if (last_pixel) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d       = DONE;
        frame_count_d = frame_count_q + 8'd1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      vga_plot_q    <= vga_plot_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign vga_plot    = vga_plot_q;
  assign busy        = (state_q == SWEEP) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_screen_flusher.sv
// tb/tb_screen_flusher.sv - self-checking bench for screen_flusher on a 4x3 screen.
module tb_screen_flusher;
  import screen_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [5:0] bg_colour = 6'h00;
  logic [5:0] src_colour;
  logic       src_enable;
  logic [7:0] flush_x, flush_y, vga_x, vga_y, frame_count;
  logic [5:0] vga_colour;
  logic       vga_plot, busy, done;

  logic       en_map  [N];
  logic [5:0] col_map [N];
  logic [5:0] last_col = 6'h00;
  int         exp_fc = 0;
  int         compared = 0;
  int         mismatched = 0;

  always #5 clock = ~clock;

  screen_flusher #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .hold        (hold),
    .bg_colour   (bg_colour),
    .src_colour  (src_colour),
    .src_enable  (src_enable),
    .flush_x     (flush_x),
    .flush_y     (flush_y),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count)
  );

  // Pixel sources: a lookup table indexed by the presented coordinate.
  always_comb begin
    src_enable = 1'b0;
    src_colour = 6'h00;
    if (int'(flush_x) < W && int'(flush_y) < H) begin
      src_enable = en_map[int'(flush_y) * W + int'(flush_x)];
      src_colour = col_map[int'(flush_y) * W + int'(flush_x)];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic model_plot(input int p);
`ifdef SCREEN_FLUSHER_BG_FILL_EN
    return 1'b1;
`else
    return en_map[p];
`endif
  endfunction

  function automatic logic [5:0] model_colour(input int p);
    if (en_map[p]) return col_map[p];
`ifdef SCREEN_FLUSHER_BG_FILL_EN
    return bg_colour;
`else
    return last_col;
`endif
  endfunction

  task automatic fill_random();
    for (int p = 0; p < N; p++) begin
      en_map[p]  = 1'($urandom_range(0, 1));
      col_map[p] = 6'($urandom);
    end
  endtask

  task automatic fill_const(input logic en, input logic [5:0] col);
    for (int p = 0; p < N; p++) begin
      en_map[p]  = en;
      col_map[p] = col;
    end
  endtask

  task automatic run_frame(input int hold_at, input int hold_len, input bit restart);
    int idx = 0;
    int held = 0;
    int cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (idx < N) begin
      chk("sweep_x", flush_x, idx % W);
      chk("sweep_y", flush_y, idx / W);
      chk("sweep_busy", busy, 1);
      if (idx == hold_at && held < hold_len) begin
        hold = 1'b1;
        step();
        hold = 1'b0;
        cyc++;
        held++;
        chk("hold_plot", vga_plot, 0);
        if (idx > 0) begin
          chk("hold_keep_x", vga_x, (idx - 1) % W);
          chk("hold_keep_colour", vga_colour, last_col);
        end
      end else begin
        if (restart && idx == 5) start = 1'b1;
        step();
        start = 1'b0;
        cyc++;
        chk("plot", vga_plot, model_plot(idx));
        if (model_plot(idx)) begin
          chk("plot_x", vga_x, idx % W);
          chk("plot_y", vga_y, idx / W);
          chk("plot_colour", vga_colour, model_colour(idx));
          last_col = model_colour(idx);
        end
        idx++;
      end
    end
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    chk("drain_xy", {vga_x, vga_y}, {8'(W - 1), 8'(H - 1)});
    chk("drain_flush", {flush_x, flush_y}, 0);
    step();
    cyc++;
    exp_fc = (exp_fc + 1) % 256;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_plot", vga_plot, 0);
    chk("done_cycles", cyc, N + 2 + held);
    chk("frame_count", frame_count, exp_fc);
    if (restart) start = 1'b1;
    step();
    start = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    step();
    chk("idle_no_restart", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flush", {flush_x, flush_y}, 0);
    chk("rst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
    chk("rst_fc", frame_count, 0);
    resetn = 1'b1;
    step();
    step();
    chk("idle_busy_no_start", busy, 0);

    // Single enabled pixel at (1,2), colour 3F
    fill_const(1'b0, 6'h11);
    en_map[9]  = 1'b1;
    col_map[9] = 6'h3F;
    run_frame(-1, 0, 1'b0);

    // Hold for three cycles at (3,0)
    fill_random();
    run_frame(3, 3, 1'b0);

    // Extra start pulses during SWEEP and in the done cycle
    fill_random();
    run_frame(-1, 0, 1'b1);
    fill_random();
    run_frame(-1, 0, 1'b0);
    chk("fc_after_restart", frame_count, 4);

    // Background fill colour (no effect unless the feature is built in)
    bg_colour = 6'h05;
    fill_const(1'b0, 6'h2A);
    run_frame(-1, 0, 1'b0);

    // Randomized frames with random hold placement
    for (int f = 0; f < 4; f++) begin
      fill_random();
      bg_colour = 6'($urandom);
      run_frame($urandom_range(0, N - 1), $urandom_range(0, 3), 1'b0);
    end

    // Reset mid-SWEEP at pixel (2,1)
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("pre_reset_flush", {flush_x, flush_y}, {8'd2, 8'd1});
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_flush", {flush_x, flush_y}, 0);
    chk("mid_rst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fc", frame_count, 0);
    step();
    chk("mid_rst_no_done", done, 0);
    resetn = 1'b1;
    exp_fc = 0;
    last_col = 6'h00;
    step();
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);

    // 256 back-to-back frames: frame_count wraps
    fill_const(1'b0, 6'h00);
    for (int f = 0; f < 256; f++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      c = 0;
      while (!done && c < 40) begin
        step();
        c++;
      end
      chk("wrap_done_seen", done, 1);
      chk("wrap_latency", c, N + 1);
      chk("wrap_fc", frame_count, (f + 1) % 256);
      step();
    end
    chk("wrap_final_fc", frame_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
